// File: rtl/sha2_block_engine.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sha2_block_engine                                          |
// | Description : Multi-block SHA-256 / SHA-224 compression engine for the   |
// |               Hash160 datapath. Accepts pre-padded 512-bit blocks over a |
// |               valid/ready handshake, runs RPC rounds per clock and keeps |
// |               the chaining value internally so long messages stream in  |
// |               block by block. Sits between the message padder and the   |
// |               RIPEMD-160 stage.                                          |
// |                                                                          |
// | Parameters  : RPC   - rounds per clock, 1/2/4/8                          |
// |               CNT_W - round counter width, must hold 64                  |
// |                                                                          |
// | Ports       : clk, rst      - clock (rising edge), sync active-high reset|
// |               in_valid/in_ready   - block input handshake                |
// |               in_block      - 512-bit block, W0 at [511:480]             |
// |               in_first      - block starts a new message (chain from IV) |
// |               in_mode       - 0 = SHA-256, 1 = SHA-224 (with in_first)   |
// |               out_valid/out_ready - digest output handshake              |
// |               digest        - H0..H7, H0 at [255:224]; [31:0]=0 in 224   |
// |               busy          - rounds are being computed                  |
// |               iv_in         - external SHA-256 IV (SHA2_EXT_IV_EN only)  |
// |                                                                          |
// | Options     : define SHA2_EXT_IV_EN to add iv_in, which replaces the     |
// |               SHA-256 constant IV on a first block (midstate resume).    |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sha2_block_engine #(
    parameter int RPC   = 1,
    parameter int CNT_W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_mode,
`ifdef SHA2_EXT_IV_EN
    input  logic [255:0] iv_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sha2_block_engine: RPC must be 1, 2, 4 or 8");
    end
    if (CNT_W < 7) begin : g_bad_cnt_w
        $error("sha2_block_engine: CNT_W must be at least 7 to hold 64");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [255:0] c_IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] c_IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // SHA-2 primitive functions (all arithmetic wraps at 32 bits)
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_bsig0(input logic [31:0] x);
        return f_rotr(x, 2) ^ f_rotr(x, 13) ^ f_rotr(x, 22);
    endfunction

    function automatic logic [31:0] f_bsig1(input logic [31:0] x);
        return f_rotr(x, 6) ^ f_rotr(x, 11) ^ f_rotr(x, 25);
    endfunction

    function automatic logic [31:0] f_ssig0(input logic [31:0] x);
        return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_ssig1(input logic [31:0] x);
        return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] f_round(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + f_bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = f_bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state_q,     w_state_d;
    logic               r_in_ready_q,  w_in_ready_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_busy_q,      w_busy_d;
    logic               r_mode_q,      w_mode_d;
    logic [CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic [511:0]       r_sched_q,     w_sched_d;   // W[t] .. W[t+15], W[t] at MSB
    logic [255:0]       r_work_q,      w_work_d;    // a..h
    logic [255:0]       r_chain_q,     w_chain_d;   // IV or previous digest
    logic [255:0]       r_digest_q,    w_digest_d;

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    logic [31:0]        w_ext [0:15+RPC];   // window plus RPC new schedule words
    logic [255:0]       w_st  [0:RPC];      // working state after each round
    logic [5:0]         w_kidx;
    logic [511:0]       w_sched_next;
    logic [255:0]       w_sum;
    logic [CNT_W-1:0]   w_cnt_step;
    logic [255:0]       w_iv;

    always_comb begin
        w_kidx       = '0;
        w_sched_next = '0;
        w_sum        = '0;

        for (int k = 0; k < 16; k++) begin
            w_ext[k] = r_sched_q[511 - 32*k -: 32];
        end
        // New words depend on earlier new words when RPC > 2, so they are
        // computed in order within this block.
        for (int j = 0; j < RPC; j++) begin
            w_ext[16+j] = f_ssig1(w_ext[14+j]) + w_ext[9+j]
                        + f_ssig0(w_ext[1+j]) + w_ext[j];
        end

        w_st[0] = r_work_q;
        for (int i = 0; i < RPC; i++) begin
            // The counter is a multiple of RPC below 64 during rounds, so the
            // 6-bit index never wraps while the result is used.
            w_kidx    = r_cnt_q[5:0] + 6'(i);
            w_st[i+1] = f_round(w_st[i], c_K[w_kidx], w_ext[i]);
        end

        for (int k = 0; k < 16; k++) begin
            w_sched_next[511 - 32*k -: 32] = w_ext[k + RPC];
        end

        for (int k = 0; k < 8; k++) begin
            w_sum[255 - 32*k -: 32] = r_chain_q[255 - 32*k -: 32]
                                    + w_st[RPC][255 - 32*k -: 32];
        end
    end

`ifdef SHA2_EXT_IV_EN
    assign w_iv = in_mode ? c_IV224 : iv_in;
`else
    assign w_iv = in_mode ? c_IV224 : c_IV256;
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        w_busy_d      = r_busy_q;
        w_mode_d      = r_mode_q;
        w_cnt_d       = r_cnt_q;
        w_sched_d     = r_sched_q;
        w_work_d      = r_work_q;
        w_chain_d     = r_chain_q;
        w_digest_d    = r_digest_q;
        w_cnt_step    = r_cnt_q + CNT_W'(RPC);

        case (r_state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_sched_d    = in_block;
                    w_cnt_d      = '0;
                    w_state_d    = S_ROUND;
                    w_in_ready_d = 1'b0;
                    w_busy_d     = 1'b1;
                    if (in_first) begin
                        w_mode_d  = in_mode;
                        w_work_d  = w_iv;
                        w_chain_d = w_iv;
                    end else begin
                        w_work_d  = r_digest_q;
                        w_chain_d = r_digest_q;
                    end
                end
            end
            S_ROUND: begin
                w_sched_d = w_sched_next;
                w_work_d  = w_st[RPC];
                w_cnt_d   = w_cnt_step;
                if (w_cnt_step == CNT_W'(64)) begin
                    w_state_d     = S_DONE;
                    w_digest_d    = w_sum;
                    w_busy_d      = 1'b0;
                    w_out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_d     = S_IDLE;
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                end
            end
            default: begin
                w_state_d     = S_IDLE;
                w_in_ready_d  = 1'b1;
                w_out_valid_d = 1'b0;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_mode_q      <= 1'b0;
            r_cnt_q       <= '0;
            r_sched_q     <= '0;
            r_work_q      <= '0;
            r_chain_q     <= '0;
            r_digest_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
            r_mode_q      <= w_mode_d;
            r_cnt_q       <= w_cnt_d;
            r_sched_q     <= w_sched_d;
            r_work_q      <= w_work_d;
            r_chain_q     <= w_chain_d;
            r_digest_q    <= w_digest_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign busy      = r_busy_q;
    // SHA-224 exposes only H0..H6; the full H7 is still kept for chaining.
    assign digest    = r_mode_q ? {r_digest_q[255:32], 32'h0} : r_digest_q;

endmodule
`default_nettype wire

// File: tb/tb_sha2_block_engine.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sha2_block_engine                                       |
// | Description : Self-checking bench for sha2_block_engine. Four instances  |
// |               (RPC = 1, 2, 4, 8) are driven one at a time and compared   |
// |               against a textbook SHA-256/224 model plus known vectors.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sha2_block_engine;

    localparam int N_DUT = 4;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // Padded message blocks and their published digests
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO_A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_B = {448'h0, 64'h1c0};

    localparam logic [255:0] KAT_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] KAT_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] KAT_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] KAT_224   = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};

    logic                   clk = 1'b0;
    logic                   rst;
    logic [511:0]           in_block;
    logic                   in_first;
    logic                   in_mode;
    logic [N_DUT-1:0]       in_valid;
    logic [N_DUT-1:0]       in_ready;
    logic [N_DUT-1:0]       out_valid;
    logic [N_DUT-1:0]       out_ready;
    logic [N_DUT-1:0]       busy;
    logic [N_DUT*256-1:0]   digest_bus;
`ifdef SHA2_EXT_IV_EN
    logic [255:0]           iv_in = IV256;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        sha2_block_engine #(
            .RPC   (1 << g),
            .CNT_W (7)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_block  (in_block),
            .in_first  (in_first),
            .in_mode   (in_mode),
`ifdef SHA2_EXT_IV_EN
            .iv_in     (iv_in),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .digest    (digest_bus[g*256 +: 256]),
            .busy      (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cur_dut = 0;

    // Reference state per instance
    logic [255:0] m_chain [N_DUT];
    logic         m_mode  [N_DUT];
    logic [255:0] m_exp   [N_DUT];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %h expected %h", tag, cur_dut, got, exp);
        end
    endtask

    function automatic logic [255:0] dig(input int d);
        return digest_bus[d*256 +: 256];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] chain, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = chain[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = chain[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom();
        return b;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N_DUT; d++) begin
            m_chain[d] = '0;
            m_mode[d]  = 1'b0;
            m_exp[d]   = '0;
        end
    endtask

    // Offer a block at the current negedge, wait for the handshake and
    // update the model. Returns at the negedge after the accept edge.
    task automatic start_block(input int d, input logic [511:0] blk, input logic first, input logic mode);
        logic [255:0] chain;
        int waited;
        cur_dut     = d;
        in_block    = blk;
        in_first    = first;
        in_mode     = mode;
        in_valid[d] = 1'b1;
        waited      = 0;
        while (!in_ready[d] && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 256'(waited >= 300), 256'(0));
        chain = first ? (mode ? IV224 : IV256) : m_chain[d];
        if (first) m_mode[d] = mode;
        m_chain[d] = ref_compress(chain, blk);
        m_exp[d]   = m_mode[d] ? {m_chain[d][255:32], 32'h0} : m_chain[d];
        @(negedge clk);
        in_valid[d] = 1'b0;
        // Inputs are don't-care outside the accept cycle
        in_block = rand_block();
        in_first = 1'($urandom_range(0, 1));
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    // Wait for the digest, check latency and value, then take it.
    task automatic finish_block(input int d, output logic [255:0] got);
        int lat;
        cur_dut = d;
        lat     = 1;
        check("busy_in_round", 256'(busy[d]), 256'(1));
        while (!out_valid[d] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 256'(lat), 256'(64 / (1 << d) + 1));
        got = dig(d);
        check("digest", got, m_exp[d]);
        check("done_busy", 256'(busy[d]), 256'(0));
        check("done_in_ready", 256'(in_ready[d]), 256'(0));
        out_ready[d] = 1'b1;
        @(negedge clk);
        check("taken_out_valid", 256'(out_valid[d]), 256'(0));
        check("taken_in_ready", 256'(in_ready[d]), 256'(1));
        out_ready[d] = 1'b0;
    endtask

    task automatic hash(input int d, input logic [511:0] blk, input logic first, input logic mode,
                        output logic [255:0] got);
        start_block(d, blk, first, mode);
        // out_ready asserted early must not disturb the rounds
        if ($urandom_range(0, 1) == 1) out_ready[d] = 1'b1;
        finish_block(d, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] got;
        logic [255:0] held;
        int lat;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_block  = '0;
        in_first  = 1'b0;
        in_mode   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        for (int d = 0; d < N_DUT; d++) begin
            cur_dut = d;
            check("rst_in_ready", 256'(in_ready[d]), 256'(1));
            check("rst_out_valid", 256'(out_valid[d]), 256'(0));
            check("rst_busy", 256'(busy[d]), 256'(0));
            check("rst_digest", dig(d), 256'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors
        hash(0, BLK_ABC, 1'b1, 1'b0, got);
        check("kat_abc", got, KAT_ABC);
        hash(2, BLK_EMPTY, 1'b1, 1'b0, got);
        check("kat_empty", got, KAT_EMPTY);
        for (int d = 0; d < N_DUT; d++) begin
            if (d == 2) continue;
            hash(d, BLK_TWO_A, 1'b1, 1'b0, got);
            hash(d, BLK_TWO_B, 1'b0, 1'b0, got);
            check("kat_two_block", got, KAT_TWO);
        end
        hash(2, BLK_ABC, 1'b1, 1'b1, got);
        check("kat_abc_224", got, KAT_224);

        // Backpressure: digest held, no second accept while DONE
        start_block(2, BLK_ABC, 1'b1, 1'b0);
        lat = 1;
        while (!out_valid[2] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 256'(lat), 256'(17));
        held = dig(2);
        check("bp_digest", held, KAT_ABC);
        in_block    = BLK_EMPTY;
        in_first    = 1'b1;
        in_mode     = 1'b1;
        in_valid[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold_digest", dig(2), held);
            check("bp_hold_in_ready", 256'(in_ready[2]), 256'(0));
            check("bp_hold_out_valid", 256'(out_valid[2]), 256'(1));
            check("bp_hold_busy", 256'(busy[2]), 256'(0));
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 256'(in_ready[2]), 256'(1));
        check("bp_release_out_valid", 256'(out_valid[2]), 256'(0));
        check("bp_idle_digest", dig(2), KAT_ABC);
        out_ready[2] = 1'b0;

        // Reset in the middle of the rounds
        start_block(0, BLK_ABC, 1'b1, 1'b0);
        repeat (29) @(negedge clk);
        check("mid_busy", 256'(busy[0]), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cur_dut = 0;
        check("mid_rst_out_valid", 256'(out_valid[0]), 256'(0));
        check("mid_rst_in_ready", 256'(in_ready[0]), 256'(1));
        check("mid_rst_busy", 256'(busy[0]), 256'(0));
        check("mid_rst_digest", dig(0), 256'(0));
        hash(0, BLK_ABC, 1'b1, 1'b0, got);
        check("kat_abc_after_rst", got, KAT_ABC);

        // Random multi-block streams; dut3 starts by chaining from the
        // cleared digest
        for (int d = 0; d < N_DUT; d++) begin
            for (int k = 0; k < 5; k++) begin
                logic first;
                first = (d == 3 && k == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
                hash(d, rand_block(), first, 1'($urandom_range(0, 1)), got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha2_block_engine.md
Name: sha2_block_engine

Overview:
- Parametrised multi-block SHA-2 compression engine for the Hash160 datapath. Supports SHA-256 and SHA-224 modes.
- Computes 1, 2, 4 or 8 rounds per clock, selectable at elaboration.
- Keeps the chaining value internally, so long messages are hashed as a stream of pre-padded 512-bit blocks.
- Valid/ready handshakes on input and output. Sits between the message padder and the RIPEMD-160 stage.

Parameters:
- RPC, 1, rounds computed per cycle; legal values 1/2/4/8, any other value is an elaboration error.
- CNT_W, 7, width of the internal round counter; must hold 64.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  a block is offered on in_block.
- in_ready  out  1  engine can accept a block.
- in_block  in  512  pre-padded message block; W0 at [511:480].
- in_first  in  1  block starts a new message: chain from the mode IV, not from the held digest.
- in_mode  in  1  0 = SHA-256, 1 = SHA-224; sampled only when in_first=1.
- out_valid  out  1  digest for the last accepted block is available.
- out_ready  in  1  consumer takes the digest.
- digest  out  256  chaining value H0..H7, H0 at [255:224]. In SHA-224 mode bits [31:0] read as 0.
- busy  out  1  engine is in ROUND state.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - digest register=0; round counter=0; latched mode=SHA-256.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_block into the 16-word schedule window.
  - Load working vars a..h:
    - in_first=1: load the IV for in_mode and latch the mode.
    - in_first=0: load the held digest register; the latched mode is unchanged.
  - Round counter=0; go to ROUND.
- ROUND:
  - Each cycle applies RPC consecutive rounds (t .. t+RPC-1) combinationally, with K and W for each.
  - The schedule window advances by RPC words per cycle. W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - Counter += RPC. When the counter reaches 64, go to DONE and load digest register = chain + a..h, per word mod 2^32.
  - "Chain" is the IV or the previous digest used at load.
  - ROUND lasts exactly 64/RPC cycles.
- DONE:
  - out_valid=1; the digest is stable.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready=0 while in DONE, so there is no overlap of blocks.
- Latency: the accept edge to the out_valid rising edge is 64/RPC+1 cycles.
  - RPC=1 gives 65 cycles; RPC=4 gives 17 cycles.
  - Throughput is one block per 64/RPC+2 cycles when out_ready is held at 1.
- IVs:
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- Arithmetic: every addition is 32-bit wrap-around; there is no carry-out anywhere.
- in_first=0 as the very first block after reset chains from digest=0. This is legal and not flagged.
- in_block, in_first and in_mode are ignored outside IDLE. in_valid held high during ROUND/DONE is not consumed.
- out_ready asserted while not in DONE has no effect.
- The digest register holds its value in IDLE until the next block finishes.

Optional Feature:
- Macro SHA2_EXT_IV_EN.
- Defined:
  - Adds port iv_in (in, 256).
  - When in_first=1 and in_mode=0, the engine chains from iv_in sampled at accept instead of the SHA-256 constant IV.
  - SHA-224 still uses its constant IV.
  - Used for midstate resume.
- Undefined: no iv_in port; constant IVs only.

Test Plan:
- "abc" single padded block, in_first=1, mode 0, RPC=1:
  - digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - out_valid rises exactly 65 cycles after accept.
- Empty message, mode 0, RPC=4:
  - digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - Latency = 17 cycles.
- "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks (in_first=1 then 0):
  - digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Check for RPC=1, 2 and 8.
- "abc", mode 1:
  - digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
  - digest[31:0] = 0.
- Backpressure and no-overlap:
  - Hold out_ready=0 for 20 cycles after out_valid: digest stable, in_ready=0, and a second in_valid is not accepted.
  - Release out_ready: in_ready=1 the next cycle.
- Reset mid-operation:
  - Assert rst at round 30 of an "abc" hash: next cycle out_valid=0, in_ready=1, digest=0.
  - A fresh "abc" hash then gives the correct digest.
